cla_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider: the inverse operation of the team's carry-lookahead adder.
- Each iteration performs one trial subtraction through a borrow-lookahead subtractor: shift, trial subtract, restore or commit.
- Produces one quotient bit per cycle.
- Used wherever the datapath needs a small-area N-bit divide behind a start/done handshake.

---
 rtl/cla_restoring_divider_pkg.sv | 24 ++
 rtl/cla_restoring_divider_if.sv | 35 +++
 rtl/cla_restoring_divider_subtractor.sv | 51 +++++
 rtl/cla_restoring_divider.sv | 193 +++++++++++++++++++
 tb/tb_cla_restoring_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cla_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// cla_restoring_divider_pkg
// Shared definitions for the iterative restoring divider:
//   - div_state_e : controller state encoding (IDLE, CALC, DONE)
//   - cnt_width() : iteration counter width, clog2(N) with a one-bit floor
//   - DBZ_Q_FILL  : fill bit of the quotient returned on divide-by-zero
// -----------------------------------------------------------------------------
package cla_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter only has to reach N-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Divide-by-zero quotient is all ones at any width.
    localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/cla_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// cla_restoring_divider_if
// Request/result bundle of the divider.
//   start       : request, sampled only while busy=0
//   dividend    : N-bit operand, captured on an accepted start
//   divisor     : N-bit operand, captured on an accepted start
//   busy        : operation in flight
//   done        : one-cycle pulse, results valid
//   quotient    : N-bit result, held until the next accepted start
//   remainder   : N-bit result, held until the next accepted start
//   div_by_zero : set with done when divisor was zero, held with results
// Modports: master (requester), slave (divider).
// -----------------------------------------------------------------------------
interface cla_restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_restoring_divider_subtractor.sv
// -----------------------------------------------------------------------------
// cla_subtractor
// Combinational W-bit a - b computed as a + ~b + 1 with parallel-prefix
// (generate/propagate) carries instead of a ripple chain.
//   a_i      : minuend (W bits)
//   b_i      : subtrahend (W bits)
//   diff_o   : a - b modulo 2^W
//   borrow_o : 1 when a < b (inverted carry out)
// -----------------------------------------------------------------------------
module cla_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;

    assign gen  = a_i & ~b_i;
    assign prop = a_i ^ ~b_i;

    // Carry into bit i, expanded as g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin,
    // with cin tied to 1 for the two's-complement +1.
    function automatic logic lookahead_carry(input logic [W-1:0] g,
                                             input logic [W-1:0] p,
                                             input int           i);
        logic c;
        logic pp;
        c  = 1'b0;
        pp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
            c  = c | (pp & g[j]);
            pp = pp & p[j];
        end
        return c | pp;
    endfunction

    always_comb begin
        carry = '0;
        for (int i = 0; i <= W; i++) begin
            carry[i] = lookahead_carry(gen, prop, i);
        end
    end

    assign diff_o   = prop ^ carry[W-1:0];
    assign borrow_o = ~carry[W];

endmodule

// File: rtl/cla_restoring_divider.sv
// -----------------------------------------------------------------------------
// cla_restoring_divider
// Iterative restoring divider, one quotient bit per clock. Each CALC cycle
// shifts the partial remainder left by one dividend bit, trial-subtracts the
// divisor through cla_subtractor and either commits the difference (quotient
// bit 1) or keeps the shifted value (quotient bit 0).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any divide in flight
//   bus   : cla_restoring_divider_if.slave (start/operands in, results out)
//
// Timing: start accepted at edge k -> done in the cycle after edge k+N+1;
// divide-by-zero -> done in the cycle after edge k+1.
//
// Build option CLA_DIV_SIGNED_EN: operands are two's complement. Magnitudes
// are divided and result signs applied on the way out of DONE (quotient
// truncates toward zero, remainder follows the dividend sign).
// -----------------------------------------------------------------------------
module cla_restoring_divider
    import cla_restoring_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla_restoring_divider_if.slave  bus
);
    localparam int                CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     q_q, q_d;        // dividend bits shifting out, quotient in
    logic [N-1:0]     r_q, r_d;        // partial remainder, always < divisor
    logic [N-1:0]     dvs_q, dvs_d;
    logic             zero_q, zero_d;  // current operation took the /0 path
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

`ifdef CLA_DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    function automatic logic [N-1:0] negate(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    // -2^(N-1) maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
        return x[N-1] ? negate(x) : x;
    endfunction
`endif

    logic [N:0] t_w;
    logic [N:0] dt_w;
    logic       borrow_w;
    logic       unused_dt_msb;

    assign t_w = {r_q, q_q[N-1]};

    cla_subtractor #(
        .W (N + 1)
    ) u_sub (
        .a_i      (t_w),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (dt_w),
        .borrow_o (borrow_w)
    );

    // A committed difference is below the divisor, so its top bit is zero.
    assign unused_dt_msb = dt_w[N];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef CLA_DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        // Results are staged in Q/R so DONE handles both paths alike.
                        q_d     = {N{DBZ_Q_FILL}};
                        r_d     = bus.dividend;
                        zero_d  = 1'b1;
`ifdef CLA_DIV_SIGNED_EN
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
`endif
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        zero_d  = 1'b0;
`ifdef CLA_DIV_SIGNED_EN
                        q_d       = magnitude(bus.dividend);
                        dvs_d     = magnitude(bus.divisor);
                        neg_quo_d = bus.dividend[N-1] ^ bus.divisor[N-1];
                        neg_rem_d = bus.dividend[N-1];
`else
                        q_d       = bus.dividend;
                        dvs_d     = bus.divisor;
`endif
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                q_d   = {q_q[N-2:0], ~borrow_w};
                r_d   = borrow_w ? t_w[N-1:0] : dt_w[N-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end

            DONE: begin
`ifdef CLA_DIV_SIGNED_EN
                quot_d = (neg_quo_q && !zero_q) ? negate(q_q) : q_q;
                rem_d  = (neg_rem_q && !zero_q) ? negate(r_q) : r_q;
`else
                quot_d = q_q;
                rem_d  = r_q;
`endif
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible results: cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef CLA_DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Working datapath: always loaded before use, so no reset needed.
    always_ff @(posedge clk) begin
        q_q   <= q_d;
        r_q   <= r_d;
        dvs_q <= dvs_d;
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_cla_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_cla_restoring_divider
// Directed cases plus randomized operands against an arithmetic reference
// model (/ and % on plain integers). Honours CLA_DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_cla_restoring_divider;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cla_restoring_divider_if #(.N(N)) bus ();

    cla_restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer division; /0 returns all ones and the dividend.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic z);
        int sa, sb, iq, ir;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef CLA_DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            iq = sa / sb;
            ir = sa % sb;
            q  = N'(iq);
            r  = N'(ir);
            z  = 1'b0;
        end
    endtask

    // Entered and left #1 after a rising edge with busy=0.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Issues a request and checks latency, results and pulse width.
    // inj > 0 pulses a competing start in that cycle and watches a long window.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int inj);
        logic [N-1:0] eq, er;
        logic         ez;
        int           lat, ndone, exp_lat;
        ref_div(a, b, eq, er, ez);
        exp_lat = (b == '0) ? 1 : N + 1;
        lat   = -1;
        ndone = 0;
        start_op(a, b);
        for (int c = 1; c <= N + 14; c++) begin
            if (c == inj) begin
                bus.start    = 1'b1;
                bus.dividend = N'(50);
                bus.divisor  = N'(5);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    check("quotient", 32'(bus.quotient), 32'(eq));
                    check("remainder", 32'(bus.remainder), 32'(er));
                    check("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
                end
            end
            if (lat > 0 && c == lat + 1) begin
                check("quotient_held", 32'(bus.quotient), 32'(eq));
                if (inj <= 0) break;
            end
        end
        bus.start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_pulses", 32'(ndone), 32'd1);
    endtask

    initial begin
        int quiet;
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the plan.
        run_op(8'd100, 8'd7, 0);
        check("plan_100_7_q", 32'(bus.quotient), 32'd14);
        run_op(8'd255, 8'd1, 0);
        run_op(8'd3, 8'd200, 0);
        run_op(8'd5, 8'd0, 0);
        check("plan_5_0_q", 32'(bus.quotient), 32'hFF);
        run_op(8'd9, 8'd3, 0);
        check("plan_9_3_dbz", 32'(bus.div_by_zero), 32'd0);
        run_op(8'd200, 8'd9, 3);
        check("plan_200_9_q", 32'(bus.quotient), 32'd22);

        // Asynchronous reset mid-operation.
        start_op(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) quiet++;
        end
        check("no_done_after_abort", 32'(quiet), 32'd0);
        run_op(8'd100, 8'd7, 0);

        // Two's complement corner cases (plain unsigned values otherwise).
        run_op(8'hF9, 8'd2, 0);
        run_op(8'h80, 8'hFF, 0);
`ifdef CLA_DIV_SIGNED_EN
        check("signed_min_q", 32'(bus.quotient), 32'h80);
`endif

        // Randomized operands, occasionally zero divisor.
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] a, b;
            a = N'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) b = '0;
            else if ($urandom_range(0, 1) == 0) b = N'($urandom_range(1, 15));
            else b = N'($urandom_range(1, 255));
            run_op(a, b, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
